reg_file: RTL and testbench

REG_FILE -- requirements
Module: reg_file

---
 rtl/reg_file.sv | 88 ++++++++
 tb/tb_reg_file.sv | 206 ++++++++++++++++++++
 2 files changed

// File: rtl/reg_file.sv
// Architectural register file with per-register rename tags (busy + ROB id),
// commit writeback, same-cycle commit forwarding on the two source queries, and rollback.
module reg_file #(
  parameter int REG_NUM  = 32,
  parameter int DATA_W   = 32,
  parameter int ROB_ID_W = 3
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                rdy,
  input  logic                rollback,
  input  logic                commit_valid,
  input  logic [4:0]          commit_rd,
  input  logic [DATA_W-1:0]   commit_data,
  input  logic [ROB_ID_W-1:0] commit_rob_id,
  input  logic                rename_valid,
  input  logic [4:0]          rename_rd,
  input  logic [ROB_ID_W-1:0] rename_rob_id,
  input  logic [4:0]          rs1_id,
  input  logic [4:0]          rs2_id,
  output logic                rs1_busy,
  output logic                rs2_busy,
  output logic [ROB_ID_W-1:0] rs1_rob_id,
  output logic [ROB_ID_W-1:0] rs2_rob_id,
  output logic [DATA_W-1:0]   rs1_val,
  output logic [DATA_W-1:0]   rs2_val
);

  logic [DATA_W-1:0]   r_value [REG_NUM];
  logic                r_busy  [REG_NUM];
  logic [ROB_ID_W-1:0] r_tag   [REG_NUM];

  genvar gi;
  generate
    for (gi = 0; gi < REG_NUM; gi++) begin : g_reg
      if (gi == 0) begin : g_zero
        always_ff @(posedge clk) begin
          r_value[gi] <= '0;
          r_busy[gi]  <= 1'b0;
          r_tag[gi]   <= '0;
        end
      end else begin : g_arch
        logic w_commit_hit;
        logic w_rename_hit;
        assign w_commit_hit = commit_valid && (commit_rd == 5'(gi));
        assign w_rename_hit = rename_valid && (rename_rd == 5'(gi));

        // Rollback beats rename, rename beats the commit's busy clear.
        always_ff @(posedge clk) begin
          if (rst) begin
            r_value[gi] <= '0;
            r_busy[gi]  <= 1'b0;
            r_tag[gi]   <= '0;
          end else if (rdy) begin
            if (w_commit_hit)
              r_value[gi] <= commit_data;
            if (rollback) begin
              r_busy[gi] <= 1'b0;
              r_tag[gi]  <= '0;
            end else if (w_rename_hit) begin
              r_busy[gi] <= 1'b1;
              r_tag[gi]  <= rename_rob_id;
            end else if (w_commit_hit && r_tag[gi] == commit_rob_id) begin
              r_busy[gi] <= 1'b0;
            end
          end
        end
      end
    end
  endgenerate

  logic w_rs1_fwd;
  logic w_rs2_fwd;

  // A commit retiring the very producer a source waits on resolves it this cycle.
  assign w_rs1_fwd = commit_valid && (rs1_id != 5'd0) && (commit_rd == rs1_id) &&
                     r_busy[rs1_id] && (r_tag[rs1_id] == commit_rob_id);
  assign w_rs2_fwd = commit_valid && (rs2_id != 5'd0) && (commit_rd == rs2_id) &&
                     r_busy[rs2_id] && (r_tag[rs2_id] == commit_rob_id);

  assign rs1_busy   = r_busy[rs1_id] && !w_rs1_fwd;
  assign rs2_busy   = r_busy[rs2_id] && !w_rs2_fwd;
  assign rs1_rob_id = r_tag[rs1_id];
  assign rs2_rob_id = r_tag[rs2_id];
  assign rs1_val    = w_rs1_fwd ? commit_data : r_value[rs1_id];
  assign rs2_val    = w_rs2_fwd ? commit_data : r_value[rs2_id];

endmodule

// File: tb/tb_reg_file.sv
// Self-checking bench for reg_file: directed scenarios with literal expectations
// plus a per-cycle comparison against an array-based reference model.
module tb_reg_file;
  localparam int DATA_W = 32;
  localparam int ROB_ID_W = 3;

  logic clk = 1'b0;
  logic rst, rdy, rollback;
  logic commit_valid, rename_valid;
  logic [4:0] commit_rd, rename_rd, rs1_id, rs2_id;
  logic [DATA_W-1:0] commit_data;
  logic [ROB_ID_W-1:0] commit_rob_id, rename_rob_id;
  logic rs1_busy, rs2_busy;
  logic [ROB_ID_W-1:0] rs1_rob_id, rs2_rob_id;
  logic [DATA_W-1:0] rs1_val, rs2_val;

  int n_checks = 0;
  int n_fail = 0;
  bit started = 0;

  logic [DATA_W-1:0]   m_val  [32];
  logic                m_busy [32];
  logic [ROB_ID_W-1:0] m_tag  [32];

  reg_file #(.REG_NUM(32), .DATA_W(DATA_W), .ROB_ID_W(ROB_ID_W)) dut (
    .clk(clk), .rst(rst), .rdy(rdy), .rollback(rollback),
    .commit_valid(commit_valid), .commit_rd(commit_rd), .commit_data(commit_data),
    .commit_rob_id(commit_rob_id), .rename_valid(rename_valid), .rename_rd(rename_rd),
    .rename_rob_id(rename_rob_id), .rs1_id(rs1_id), .rs2_id(rs2_id),
    .rs1_busy(rs1_busy), .rs2_busy(rs2_busy), .rs1_rob_id(rs1_rob_id),
    .rs2_rob_id(rs2_rob_id), .rs1_val(rs1_val), .rs2_val(rs2_val)
  );

  always #5 clk = ~clk;

  // Reference model: apply the edge's effects in order of increasing priority.
  always @(posedge clk) begin
    if (rst) begin
      started = 1;
      for (int i = 0; i < 32; i++) begin
        m_val[i] = '0; m_busy[i] = 0; m_tag[i] = '0;
      end
    end else if (started && rdy) begin
      if (commit_valid && commit_rd != 0) begin
        if (m_busy[commit_rd] && m_tag[commit_rd] == commit_rob_id)
          m_busy[commit_rd] = 0;
        m_val[commit_rd] = commit_data;
      end
      if (rename_valid && rename_rd != 0) begin
        m_busy[rename_rd] = 1;
        m_tag[rename_rd] = rename_rob_id;
      end
      if (rollback)
        for (int i = 0; i < 32; i++) begin
          m_busy[i] = 0; m_tag[i] = '0;
        end
    end
  end

  task automatic cmp(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_port(input string nm, input logic [4:0] id, input logic busy,
                            input logic [ROB_ID_W-1:0] tag, input logic [DATA_W-1:0] val);
    logic fwd;
    logic e_busy;
    logic [DATA_W-1:0] e_val;
    fwd = commit_valid && id != 0 && commit_rd == id && m_busy[id] && m_tag[id] == commit_rob_id;
    e_busy = m_busy[id] && !fwd;
    e_val = fwd ? commit_data : m_val[id];
    cmp({nm, "_busy"}, 32'(busy), 32'(e_busy));
    if (e_busy) cmp({nm, "_rob_id"}, 32'(tag), 32'(m_tag[id]));
    else        cmp({nm, "_val"}, val, e_val);
  endtask

  always @(negedge clk) begin
    if (started && !rst) begin
      model_port("model_rs1", rs1_id, rs1_busy, rs1_rob_id, rs1_val);
      model_port("model_rs2", rs2_id, rs2_busy, rs2_rob_id, rs2_val);
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic quiet();
    commit_valid = 0; rename_valid = 0; rollback = 0;
  endtask

  task automatic commit(input logic [4:0] rd, input logic [ROB_ID_W-1:0] tag, input logic [31:0] d);
    commit_valid = 1; commit_rd = rd; commit_rob_id = tag; commit_data = d;
  endtask

  task automatic rename(input logic [4:0] rd, input logic [ROB_ID_W-1:0] tag);
    rename_valid = 1; rename_rd = rd; rename_rob_id = tag;
  endtask

  initial begin
    rst = 1; rdy = 1; quiet();
    commit_rd = 0; commit_data = 0; commit_rob_id = 0;
    rename_rd = 0; rename_rob_id = 0; rs1_id = 0; rs2_id = 0;
    step(); step();
    rst = 0;
    rs1_id = 5; rs2_id = 31; #1;
    cmp("reset_rs1_busy", 32'(rs1_busy), 0);
    cmp("reset_rs1_rob_id", 32'(rs1_rob_id), 0);
    cmp("reset_rs2_val", rs2_val, 0);

    // Rename then forwarded commit of x5
    rename(5, 3); step(); quiet(); #1;
    cmp("x5_busy", 32'(rs1_busy), 1);
    cmp("x5_rob_id", 32'(rs1_rob_id), 3);
    commit(5, 3, 32'hDEADBEEF); #1;
    cmp("x5_fwd_busy", 32'(rs1_busy), 0);
    cmp("x5_fwd_val", rs1_val, 32'hDEADBEEF);
    step(); quiet(); #1;
    cmp("x5_after_busy", 32'(rs1_busy), 0);
    cmp("x5_after_val", rs1_val, 32'hDEADBEEF);

    // Stale commit on a re-renamed register
    rename(7, 1); step(); rename(7, 4); step(); quiet();
    commit(7, 1, 32'h11); rs2_id = 7; #1;
    cmp("x7_stale_nofwd_busy", 32'(rs2_busy), 1);
    step(); quiet(); #1;
    cmp("x7_busy", 32'(rs2_busy), 1);
    cmp("x7_rob_id", 32'(rs2_rob_id), 4);

    // Same-cycle commit and rename to x9
    commit(9, 2, 32'h55); rename(9, 6); step(); quiet(); rs1_id = 9; #1;
    cmp("x9_busy", 32'(rs1_busy), 1);
    cmp("x9_rob_id", 32'(rs1_rob_id), 6);

    // Rollback with coincident commit and discarded rename
    rename(1, 1); step(); rename(2, 2); step(); rename(3, 3); step(); quiet();
    rollback = 1; commit(1, 7, 32'hAA); rename(4, 5); step(); quiet();
    rs1_id = 1; rs2_id = 4; #1;
    cmp("rb_x1_busy", 32'(rs1_busy), 0);
    cmp("rb_x1_val", rs1_val, 32'hAA);
    cmp("rb_x4_busy", 32'(rs2_busy), 0);
    rs1_id = 9; rs2_id = 3; #1;
    cmp("rb_x9_val", rs1_val, 32'h55);
    cmp("rb_x3_busy", 32'(rs2_busy), 0);
    rs2_id = 7; #1;
    cmp("rb_x7_val", rs2_val, 32'h11);

    // x0 is hardwired
    commit(0, 0, 32'hFFFFFFFF); rename(0, 2); rs1_id = 0; #1;
    cmp("x0_fwd_val", rs1_val, 0);
    step(); quiet(); #1;
    cmp("x0_busy", 32'(rs1_busy), 0);
    cmp("x0_val", rs1_val, 0);

    // Frozen while rdy=0
    rdy = 0; commit(6, 0, 32'h66); rename(6, 1); step(); quiet(); rdy = 1;
    rs1_id = 6; #1;
    cmp("x6_frozen_busy", 32'(rs1_busy), 0);
    cmp("x6_frozen_val", rs1_val, 0);

    // Tag-mismatched commit writes value only
    rename(10, 2); step(); quiet();
    commit(10, 5, 32'h77); rs1_id = 10; #1;
    cmp("x10_mis_nofwd", 32'(rs1_busy), 1);
    step(); quiet(); #1;
    cmp("x10_mis_busy", 32'(rs1_busy), 1);
    cmp("x10_mis_tag", 32'(rs1_rob_id), 2);
    commit(10, 2, 32'h78); step(); quiet(); #1;
    cmp("x10_val", rs1_val, 32'h78);

    // Reset mid-stream
    commit(8, 0, 32'h1234); step(); quiet(); rename(8, 4); step(); quiet();
    rs1_id = 8; #1;
    cmp("x8_busy_pre", 32'(rs1_busy), 1);
    rst = 1; commit(8, 4, 32'h9); step(); quiet(); rst = 0; #1;
    cmp("x8_rst_busy", 32'(rs1_busy), 0);
    cmp("x8_rst_val", rs1_val, 0);

    // Mixed traffic, checked against the model every cycle
    for (int i = 0; i < 200; i++) begin
      rdy = ($urandom_range(0, 7) != 0);
      rollback = ($urandom_range(0, 15) == 0);
      commit_valid = $urandom_range(0, 1);
      commit_rd = 5'($urandom_range(0, 7));
      commit_rob_id = ROB_ID_W'($urandom_range(0, 7));
      commit_data = $urandom;
      rename_valid = $urandom_range(0, 1);
      rename_rd = 5'($urandom_range(0, 7));
      rename_rob_id = ROB_ID_W'($urandom_range(0, 7));
      rs1_id = 5'($urandom_range(0, 7));
      rs2_id = 5'($urandom_range(0, 7));
      if ($urandom_range(0, 1) == 1 && m_busy[commit_rd]) commit_rob_id = m_tag[commit_rd];
      step();
    end
    quiet(); rdy = 1;
    step();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
